// File: rtl/imsic_csr_req.sv
// Hart-side initiator for the IMSIC interrupt-file CSR channel: one indirect
// access at a time, plus topei claim via a clear-bit write to the matching eip.
module imsic_csr_req #(
    parameter int XLEN           = 64,
    parameter int NR_INTP_FILES  = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_vld,
    output logic            o_req_rdy,
    input  logic [11:0]     i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_req_op,
    input  logic            i_req_claim,
    input  logic            i_req_v,
    input  logic [5:0]      i_req_vgein,
    input  logic [31:0]     i_xtopei,
    output logic [11:0]     o_csr_addr,
    output logic            o_csr_rd,
    output logic            o_csr_wdata_vld,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic [1:0]      o_csr_wdata_op,
    output logic            o_csr_v,
    output logic [5:0]      o_csr_vgein,
    input  logic            i_csr_rdata_vld,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic            i_csr_illegal,
    output logic            o_rsp_vld,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_illegal,
    output logic            o_rsp_timeout
);

    localparam int              SHW       = $clog2(XLEN);
    localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]      VGEIN_MAX = 6'(NR_INTP_FILES - 3);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic              claim_r;
    logic [31:0]       xtopei_r;
    logic              wvld_r;
    logic [11:0]       csr_addr_r;
    logic [XLEN-1:0]   csr_wdata_r;
    logic [1:0]        csr_op_r;
    logic              csr_v_r;
    logic [5:0]        csr_vgein_r;
    logic [XLEN-1:0]   rsp_rdata_r;
    logic              rsp_illegal_r;
    logic              rsp_timeout_r;

    logic              accept_s;
    logic              local_bad_s;
    logic              claim_zero_s;
    logic              no_access_s;
    logic              cnt_done_s;
    logic [10:0]       claim_id_s;
    logic [10:0]       claim_idx_s;
    logic [11:0]       claim_addr_s;
    logic [XLEN-1:0]   claim_bit_s;

    assign accept_s     = i_req_vld & (state_r == IDLE);
    assign local_bad_s  = i_req_v & (i_req_vgein > VGEIN_MAX);
    assign claim_id_s   = i_xtopei[26:16];
    assign claim_zero_s = i_req_claim & (claim_id_s == 11'd0);
    assign no_access_s  = local_bad_s | claim_zero_s;
    assign cnt_done_s   = (cnt_r == CNT_LAST);

    // eip registers are XLEN wide; on RV64 only the even-numbered ones exist.
    assign claim_idx_s  = claim_id_s >> SHW;
    assign claim_addr_s = (XLEN == 64) ? (12'h080 + {claim_idx_s, 1'b0})
                                       : (12'h080 + {1'b0, claim_idx_s});
    assign claim_bit_s  = {{(XLEN-1){1'b0}}, 1'b1} << claim_id_s[SHW-1:0];

    // Strobe, qualifier, ready and response pulse are decoded from state.
    assign o_req_rdy       = (state_r == IDLE);
    assign o_csr_rd        = (state_r == ISSUE);
    assign o_csr_wdata_vld = (state_r == ISSUE) & wvld_r;
    assign o_rsp_vld       = (state_r == RESP);
    assign o_csr_addr      = csr_addr_r;
    assign o_csr_wdata     = csr_wdata_r;
    assign o_csr_wdata_op  = csr_op_r;
    assign o_csr_v         = csr_v_r;
    assign o_csr_vgein     = csr_vgein_r;
    assign o_rsp_rdata     = rsp_rdata_r;
    assign o_rsp_illegal   = rsp_illegal_r;
    assign o_rsp_timeout   = rsp_timeout_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (no_access_s) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (i_csr_rdata_vld || cnt_done_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // WAIT-cycle counter; held at zero outside WAIT so it restarts on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r != WAIT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Request latch, channel drive values and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            claim_r       <= 1'b0;
            xtopei_r      <= 32'd0;
            wvld_r        <= 1'b0;
            csr_addr_r    <= 12'd0;
            csr_wdata_r   <= '0;
            csr_op_r      <= 2'b00;
            csr_v_r       <= 1'b0;
            csr_vgein_r   <= 6'd0;
            rsp_rdata_r   <= '0;
            rsp_illegal_r <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (accept_s) begin
            claim_r  <= i_req_claim;
            xtopei_r <= i_xtopei;
            if (no_access_s) begin
                rsp_rdata_r   <= '0;
                rsp_illegal_r <= local_bad_s;
                rsp_timeout_r <= 1'b0;
            end else begin
                csr_v_r     <= i_req_v;
                csr_vgein_r <= i_req_vgein;
                if (i_req_claim) begin
                    csr_addr_r  <= claim_addr_s;
                    csr_wdata_r <= claim_bit_s;
                    csr_op_r    <= 2'b11;
                    wvld_r      <= 1'b1;
                end else begin
                    csr_addr_r  <= i_req_addr;
                    csr_wdata_r <= i_req_wdata;
                    csr_op_r    <= i_req_op;
                    wvld_r      <= (i_req_op != 2'b00);
                end
            end
        end else if (state_r == WAIT) begin
            if (i_csr_rdata_vld) begin
                rsp_rdata_r   <= claim_r ? XLEN'(xtopei_r) : i_csr_rdata;
                rsp_illegal_r <= i_csr_illegal;
                rsp_timeout_r <= 1'b0;
            end else if (cnt_done_s) begin
                rsp_rdata_r   <= '0;
                rsp_illegal_r <= 1'b1;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imsic_csr_req.sv
// Bench for imsic_csr_req: directed plan items plus randomized requests checked
// against a transaction-level reference model.
module tb_imsic_csr_req;

    localparam int XLEN = 64;
    localparam int NR   = 7;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req_vld;
    logic            o_req_rdy;
    logic [11:0]     i_req_addr;
    logic [XLEN-1:0] i_req_wdata;
    logic [1:0]      i_req_op;
    logic            i_req_claim;
    logic            i_req_v;
    logic [5:0]      i_req_vgein;
    logic [31:0]     i_xtopei;
    logic [11:0]     o_csr_addr;
    logic            o_csr_rd;
    logic            o_csr_wdata_vld;
    logic [XLEN-1:0] o_csr_wdata;
    logic [1:0]      o_csr_wdata_op;
    logic            o_csr_v;
    logic [5:0]      o_csr_vgein;
    logic            i_csr_rdata_vld;
    logic [XLEN-1:0] i_csr_rdata;
    logic            i_csr_illegal;
    logic            o_rsp_vld;
    logic [XLEN-1:0] o_rsp_rdata;
    logic            o_rsp_illegal;
    logic            o_rsp_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // Last channel values and last response, as the model expects them held.
    logic [11:0]     lc_addr;
    logic [XLEN-1:0] lc_wdata;
    logic [1:0]      lc_op;
    logic            lc_v;
    logic [5:0]      lc_vgein;
    logic [XLEN-1:0] pr_rdata;
    logic            pr_ill;
    logic            pr_tmo;

    imsic_csr_req #(.XLEN(XLEN), .NR_INTP_FILES(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_op(i_req_op),
        .i_req_claim(i_req_claim), .i_req_v(i_req_v), .i_req_vgein(i_req_vgein),
        .i_xtopei(i_xtopei),
        .o_csr_addr(o_csr_addr), .o_csr_rd(o_csr_rd), .o_csr_wdata_vld(o_csr_wdata_vld),
        .o_csr_wdata(o_csr_wdata), .o_csr_wdata_op(o_csr_wdata_op),
        .o_csr_v(o_csr_v), .o_csr_vgein(o_csr_vgein),
        .i_csr_rdata_vld(i_csr_rdata_vld), .i_csr_rdata(i_csr_rdata),
        .i_csr_illegal(i_csr_illegal),
        .o_rsp_vld(o_rsp_vld), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_illegal(o_rsp_illegal), .o_rsp_timeout(o_rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic scramble_req();
        i_req_addr  = 12'($urandom);
        i_req_wdata = {$urandom, $urandom};
        i_req_op    = 2'($urandom);
        i_req_claim = 1'($urandom);
        i_req_v     = 1'($urandom);
        i_req_vgein = 6'($urandom);
        i_xtopei    = $urandom;
    endtask

    // One request through the DUT; d = WAIT cycles before the reply (>= TMO: none).
    task automatic run_txn(input logic claim, input logic [1:0] op, input logic [11:0] addr,
                           input logic [63:0] wdata, input logic v, input logic [5:0] vgein,
                           input logic [31:0] xtopei, input int d,
                           input logic [63:0] rd, input logic ill);
        int id;
        logic bad, acc, e_wvld, e_ill, e_tmo;
        int rsp_c, rep_c;
        logic [11:0] e_addr;
        logic [63:0] e_wdata, e_rdata;
        logic [1:0] e_op;

        id    = int'(xtopei[26:16]);
        bad   = v && (int'(vgein) > NR - 3);
        acc   = !bad && !(claim && id == 0);
        rep_c = -1;
        if (!acc) begin
            rsp_c = 1; e_rdata = 64'd0; e_ill = bad; e_tmo = 1'b0;
        end else if (d < TMO) begin
            rep_c = 2 + d; rsp_c = 3 + d;
            e_rdata = claim ? {32'd0, xtopei} : rd;
            e_ill = ill; e_tmo = 1'b0;
        end else begin
            rsp_c = TMO + 2; e_rdata = 64'd0; e_ill = 1'b1; e_tmo = 1'b1;
        end
        e_addr  = claim ? 12'(128 + (id / XLEN) * 2) : addr;
        e_wdata = claim ? (64'd1 << (id % XLEN)) : wdata;
        e_op    = claim ? 2'b11 : op;
        e_wvld  = claim || (op != 2'b00);

        @(posedge clk); #1;
        i_req_claim = claim; i_req_op = op; i_req_addr = addr; i_req_wdata = wdata;
        i_req_v = v; i_req_vgein = vgein; i_xtopei = xtopei; i_req_vld = 1'b1;
        @(negedge clk);
        chk_val("rdy_idle", o_req_rdy, 1'b1);
        @(posedge clk); #1;
        i_req_vld = 1'b0;
        scramble_req();
        for (int c = 1; c <= rsp_c; c++) begin
            i_csr_rdata_vld = (c == rep_c);
            i_csr_rdata     = rd;
            i_csr_illegal   = ill;
            @(negedge clk);
            chk_val("csr_rd", o_csr_rd, acc && c == 1);
            chk_val("wdata_vld", o_csr_wdata_vld, acc && c == 1 && e_wvld);
            chk_val("rdy_busy", o_req_rdy, 1'b0);
            chk_val("rsp_vld", o_rsp_vld, c == rsp_c);
            if (acc && c == 1) begin
                chk_val("csr_addr", o_csr_addr, e_addr);
                chk_val("csr_op", o_csr_wdata_op, e_op);
                chk_val("csr_v", o_csr_v, v);
                chk_val("csr_vgein", o_csr_vgein, vgein);
                if (e_wvld) chk_val("csr_wdata", o_csr_wdata, e_wdata);
            end
            if (c == 1 && rsp_c > 1) begin
                chk_val("rdata_hold", o_rsp_rdata, pr_rdata);
                chk_val("tmo_hold", o_rsp_timeout, pr_tmo);
            end
            if (c == rsp_c) begin
                chk_val("rsp_rdata", o_rsp_rdata, e_rdata);
                chk_val("rsp_illegal", o_rsp_illegal, e_ill);
                chk_val("rsp_timeout", o_rsp_timeout, e_tmo);
                if (!acc) begin
                    chk_val("ch_addr_hold", o_csr_addr, lc_addr);
                    chk_val("ch_op_hold", o_csr_wdata_op, lc_op);
                    chk_val("ch_vgein_hold", o_csr_vgein, lc_vgein);
                end
            end
            if (c < rsp_c) begin
                @(posedge clk); #1;
            end
        end
        if (acc) begin
            lc_addr = e_addr; lc_op = e_op; lc_v = v; lc_vgein = vgein;
            if (e_wvld) lc_wdata = e_wdata;
        end
        pr_rdata = e_rdata; pr_ill = e_ill; pr_tmo = e_tmo;
        @(posedge clk); #1;
        i_csr_rdata_vld = 1'b0;
        @(negedge clk);
        chk_val("rdy_after", o_req_rdy, 1'b1);
        chk_val("rsp_vld_after", o_rsp_vld, 1'b0);
        chk_val("rsp_illegal_hold", o_rsp_illegal, pr_ill);
    endtask

    initial begin
        rst = 1'b1; i_req_vld = 1'b0; i_csr_rdata_vld = 1'b0;
        i_csr_rdata = 64'd0; i_csr_illegal = 1'b0;
        scramble_req();
        lc_addr = 12'd0; lc_wdata = 64'd0; lc_op = 2'b00; lc_v = 1'b0; lc_vgein = 6'd0;
        pr_rdata = 64'd0; pr_ill = 1'b0; pr_tmo = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_val("rst_rdy", o_req_rdy, 1'b1);
        chk_val("rst_rd", o_csr_rd, 1'b0);
        chk_val("rst_addr", o_csr_addr, 12'd0);
        chk_val("rst_v", o_csr_v, 1'b0);
        chk_val("rst_vgein", o_csr_vgein, 6'd0);
        chk_val("rst_rsp_vld", o_rsp_vld, 1'b0);
        chk_val("rst_rdata", o_rsp_rdata, 64'd0);

        // Read eidelivery, set eie0 with illegal reply, claim id 0x45.
        run_txn(1'b0, 2'b00, 12'h070, 64'd0, 1'b0, 6'd0, 32'd0, 0, 64'd1, 1'b0);
        run_txn(1'b0, 2'b10, 12'h0C0, 64'h6, 1'b0, 6'd0, 32'd0, 0, 64'hDEAD_BEEF, 1'b1);
        run_txn(1'b1, 2'b00, 12'h000, 64'd0, 1'b0, 6'd0, 32'h0045_0045, 0, 64'h1234, 1'b0);
        // Claim with no pending id, bad vgein, and the highest legal vgein.
        run_txn(1'b1, 2'b01, 12'h0FF, 64'd5, 1'b0, 6'd0, 32'h0000_0000, 0, 64'd7, 1'b0);
        run_txn(1'b0, 2'b01, 12'h071, 64'd3, 1'b1, 6'd5, 32'd0, 0, 64'd9, 1'b0);
        run_txn(1'b0, 2'b11, 12'h0C2, 64'hF0, 1'b1, 6'd4, 32'd0, 1, 64'd11, 1'b0);
        // Reply on the last WAIT cycle, then no reply at all.
        run_txn(1'b0, 2'b00, 12'h072, 64'd0, 1'b0, 6'd0, 32'd0, TMO - 1, 64'hABCD, 1'b0);
        run_txn(1'b0, 2'b00, 12'h070, 64'd0, 1'b0, 6'd0, 32'd0, 99, 64'h55, 1'b0);

        // Late reply in IDLE must not produce a response.
        @(posedge clk); #1;
        i_csr_rdata_vld = 1'b1; i_csr_rdata = 64'h77; i_csr_illegal = 1'b0;
        @(posedge clk); #1;
        i_csr_rdata_vld = 1'b0;
        @(negedge clk);
        chk_val("late_rsp_vld", o_rsp_vld, 1'b0);
        chk_val("late_rdy", o_req_rdy, 1'b1);
        chk_val("late_tmo_hold", o_rsp_timeout, 1'b1);

        // Reset while waiting for the reply drops the request silently.
        @(posedge clk); #1;
        i_req_claim = 1'b0; i_req_op = 2'b00; i_req_addr = 12'h070; i_req_v = 1'b0;
        i_req_vgein = 6'd0; i_req_vld = 1'b1;
        @(posedge clk); #1;
        i_req_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_val("rstw_rdy", o_req_rdy, 1'b1);
        chk_val("rstw_rsp_vld", o_rsp_vld, 1'b0);
        chk_val("rstw_addr", o_csr_addr, 12'd0);
        chk_val("rstw_tmo", o_rsp_timeout, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_val("rstw_quiet", o_rsp_vld, 1'b0);
        end
        lc_addr = 12'd0; lc_wdata = 64'd0; lc_op = 2'b00; lc_v = 1'b0; lc_vgein = 6'd0;
        pr_rdata = 64'd0; pr_ill = 1'b0; pr_tmo = 1'b0;
        run_txn(1'b0, 2'b00, 12'h070, 64'd0, 1'b0, 6'd0, 32'd0, 0, 64'd1, 1'b0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            logic cl;
            logic [31:0] xt;
            cl = ($urandom_range(0, 3) == 0);
            xt = $urandom;
            if ($urandom_range(0, 4) == 0) xt[26:16] = 11'd0;
            run_txn(cl, 2'($urandom), 12'($urandom), {$urandom, $urandom},
                    1'($urandom), 6'($urandom_range(0, 7)), xt,
                    int'($urandom_range(0, TMO + 1)), {$urandom, $urandom}, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
